// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the instruction fetch slice.
package rv_fetch_pkg;

    localparam int unsigned PC_WIDTH         = 32;
    localparam int unsigned INST_WIDTH       = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_t;

endpackage

// File: rtl/ifu_inst_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries; head is read straight
// from the storage registers. Flush empties the queue and wins over push/pop.
module ifu_inst_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 64
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_CNT) || do_pop);
    end

    // Storage, pointers and occupancy; reset also clears storage so head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Status flags and head entry.
    always_comb begin
        full  = (count == FULL_CNT);
        empty = (count == '0);
        head  = mem[rd_ptr];
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, addresses the combinational
// instruction memory and queues fetched words toward decode.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned redirect traps and
// halts fetch); when undefined, redirect targets are forced word aligned.
module inst_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int unsigned                PC_WIDTH_LENGTH   = PC_WIDTH,
    parameter int unsigned                INST_WIDTH_LENGTH = INST_WIDTH,
    parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC          = PC_WIDTH_LENGTH'(RESET_PC_DEFAULT),
    parameter int unsigned                QUEUE_DEPTH       = 2
)(
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH_LENGTH-1:0]   imem_pc,
    input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    output logic                         dec_valid,
    output logic [INST_WIDTH_LENGTH-1:0] dec_inst,
    output logic [PC_WIDTH_LENGTH-1:0]   dec_pc,
    input  logic                         dec_ready,
    output logic                         fault,
    output logic [PC_WIDTH_LENGTH-1:0]   fault_pc
);

    localparam int unsigned PCW = PC_WIDTH_LENGTH;
    localparam int unsigned IW  = INST_WIDTH_LENGTH;
    localparam int unsigned EW  = PCW + IW;

    localparam logic [PCW-1:0] STEP       = PCW'(PC_STEP);
    localparam logic [PCW-1:0] ALIGN_MASK = {{(PCW-2){1'b1}}, 2'b00};

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic [PCW-1:0] fetch_pc;
    logic [PCW-1:0] fetch_pc_nxt;
    logic [PCW-1:0] redirect_tgt;
    logic           redirect_bad;

    logic           q_flush;
    logic           q_push;
    logic           q_pop;
    logic           q_full;
    logic           q_empty;
    logic [EW-1:0]  q_head;

`ifdef IFU_MISALIGN_TRAP_EN
    logic [PCW-1:0] fault_pc_q;

    // Misaligned targets are trapped rather than loaded.
    always_comb begin
        redirect_bad = (redirect_pc[1:0] != 2'b00);
        redirect_tgt = redirect_pc;
    end

    // Latch the offending address of the most recent misaligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_pc_q <= '0;
        end else if (redirect_valid && redirect_bad) begin
            fault_pc_q <= redirect_pc;
        end
    end

    // Fault is sticky for as long as fetch is halted.
    always_comb begin
        fault    = (state == FETCH_HALT);
        fault_pc = fault_pc_q;
    end
`else
    // Low address bits of the target are dropped; a fault is never raised.
    always_comb begin
        redirect_bad = 1'b0;
        redirect_tgt = redirect_pc & ALIGN_MASK;
        fault        = 1'b0;
        fault_pc     = '0;
    end
`endif

    // Fetch state and PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_RUN;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // Next-state: redirect flushes and overrides push/pop; otherwise fetch
    // sequentially while the queue has room or its head drains this cycle.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        q_flush      = 1'b0;
        q_push       = 1'b0;
        q_pop        = 1'b0;
        if (redirect_valid) begin
            q_flush = 1'b1;
            if (redirect_bad) begin
                state_nxt = FETCH_HALT;
            end else begin
                state_nxt    = FETCH_RUN;
                fetch_pc_nxt = redirect_tgt;
            end
        end else begin
            q_pop = dec_valid && dec_ready;
            if ((state == FETCH_RUN) && (!q_full || q_pop)) begin
                q_push       = 1'b1;
                fetch_pc_nxt = fetch_pc + STEP;
            end
        end
    end

    ifu_inst_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .DATA_W (EW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (q_push),
        .push_data ({fetch_pc, imem_inst}),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    // Memory address and decode-side view of the queue head.
    always_comb begin
        imem_pc   = fetch_pc;
        dec_valid = !q_empty;
        dec_pc    = q_head[EW-1:IW];
        dec_inst  = q_head[IW-1:0];
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed, table-driven bench for inst_fetch_unit. Instruction memory returns
// the word index (pc >> 2). Respects IFU_MISALIGN_TRAP_EN for the fault rows.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        bit          rv;
        logic [31:0] rpc;
        bit          rdy;
        bit          chk;   // compare outputs in this cycle
        bit          ev;    // expected dec_valid
        bit          dz;    // expect dec_pc/dec_inst zero (reset state)
        logic [31:0] epc;   // expected dec_pc when ev
        logic [31:0] eimem; // expected imem_pc
        bit          ef;    // expected fault
        logic [31:0] efpc;  // expected fault_pc
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // Combinational instruction memory: mem[i] = i.
    always_comb imem_inst = imem_pc >> 2;

    inst_fetch_unit #(
        .PC_WIDTH_LENGTH   (32),
        .INST_WIDTH_LENGTH (32),
        .RESET_PC          (32'h0),
        .QUEUE_DEPTH       (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy,
                       input bit chk, input bit ev, input bit dz, input logic [31:0] epc,
                       input logic [31:0] eimem, input bit ef, input logic [31:0] efpc);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.chk = chk; v.ev = ev; v.dz = dz; v.epc = epc;
        v.eimem = eimem; v.ef = ef; v.efpc = efpc;
        vecs.push_back(v);
    endtask

    // Compare current outputs against expectations (called at negedge).
    task automatic check_outputs(input string tag, input bit ev, input bit dz,
                                 input logic [31:0] epc, input logic [31:0] eimem,
                                 input bit ef, input logic [31:0] efpc);
        check({tag, " dec_valid"}, {31'd0, dec_valid}, {31'd0, ev});
        check({tag, " imem_pc"}, imem_pc, eimem);
        check({tag, " fault"}, {31'd0, fault}, {31'd0, ef});
        check({tag, " fault_pc"}, fault_pc, efpc);
        if (ev) begin
            check({tag, " dec_pc"}, dec_pc, epc);
            check({tag, " dec_inst"}, dec_inst, epc >> 2);
        end else if (dz) begin
            check({tag, " dec_pc"}, dec_pc, 32'h0);
            check({tag, " dec_inst"}, dec_inst, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

        //   rst rv rpc          rdy chk ev dz epc          eimem        ef efpc
        // Reset and streaming: first word at the 2nd cycle after rst drops.
        add(1, 0, 32'h0,        0,  0,  0, 0, 32'h0,        32'h0,        0, 32'h0);   // r0
        add(1, 0, 32'h0,        1,  1,  0, 1, 32'h0,        32'h0,        0, 32'h0);   // r1
        add(0, 0, 32'h0,        1,  1,  0, 1, 32'h0,        32'h0,        0, 32'h0);   // r2
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'h0,        32'h4,        0, 32'h0);   // r3
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'h4,        32'h8,        0, 32'h0);   // r4
        add(1, 0, 32'h0,        0,  1,  1, 0, 32'h8,        32'hC,        0, 32'h0);   // r5
        // Back-pressure: five cycles with dec_ready low, PC freezes at 8.
        add(0, 0, 32'h0,        0,  1,  0, 1, 32'h0,        32'h0,        0, 32'h0);   // r6
        add(0, 0, 32'h0,        0,  1,  1, 0, 32'h0,        32'h4,        0, 32'h0);   // r7
        add(0, 0, 32'h0,        0,  1,  1, 0, 32'h0,        32'h8,        0, 32'h0);   // r8
        add(0, 0, 32'h0,        0,  1,  1, 0, 32'h0,        32'h8,        0, 32'h0);   // r9
        add(0, 0, 32'h0,        0,  1,  1, 0, 32'h0,        32'h8,        0, 32'h0);   // r10
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'h0,        32'h8,        0, 32'h0);   // r11
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'h4,        32'hC,        0, 32'h0);   // r12
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'h8,        32'h10,       0, 32'h0);   // r13
        add(0, 0, 32'h0,        0,  1,  1, 0, 32'hC,        32'h14,       0, 32'h0);   // r14
        // Redirect while full, with a pop in the same cycle that must be discarded.
        add(0, 1, 32'h100,      1,  1,  1, 0, 32'hC,        32'h14,       0, 32'h0);   // r15
        add(0, 0, 32'h0,        1,  1,  0, 0, 32'h0,        32'h100,      0, 32'h0);   // r16
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'h100,      32'h104,      0, 32'h0);   // r17
        // Misaligned redirect.
        add(0, 1, 32'h102,      1,  1,  1, 0, 32'h104,      32'h108,      0, 32'h0);   // r18
`ifdef IFU_MISALIGN_TRAP_EN
        add(0, 0, 32'h0,        1,  1,  0, 0, 32'h0,        32'h108,      1, 32'h102); // r19
        add(0, 1, 32'hFFFFFFF8, 1,  1,  0, 0, 32'h0,        32'h108,      1, 32'h102); // r20
        add(0, 0, 32'h0,        1,  1,  0, 0, 32'h0,        32'hFFFFFFF8, 0, 32'h102); // r21
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 32'h102); // r22
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'hFFFFFFFC, 32'h0,        0, 32'h102); // r23
        add(0, 1, 32'h300,      1,  1,  1, 0, 32'h0,        32'h4,        0, 32'h102); // r24
        add(0, 1, 32'h400,      1,  1,  0, 0, 32'h0,        32'h300,      0, 32'h102); // r25
        add(0, 0, 32'h0,        1,  1,  0, 0, 32'h0,        32'h400,      0, 32'h102); // r26
        add(0, 0, 32'h0,        0,  1,  1, 0, 32'h400,      32'h404,      0, 32'h102); // r27
        add(1, 0, 32'h0,        0,  1,  1, 0, 32'h400,      32'h408,      0, 32'h102); // r28
`else
        add(0, 0, 32'h0,        1,  1,  0, 0, 32'h0,        32'h100,      0, 32'h0);   // r19
        add(0, 1, 32'hFFFFFFF8, 1,  1,  1, 0, 32'h100,      32'h104,      0, 32'h0);   // r20
        add(0, 0, 32'h0,        1,  1,  0, 0, 32'h0,        32'hFFFFFFF8, 0, 32'h0);   // r21
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 32'h0);   // r22
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'hFFFFFFFC, 32'h0,        0, 32'h0);   // r23
        // Back-to-back redirects: the last one wins.
        add(0, 1, 32'h300,      1,  1,  1, 0, 32'h0,        32'h4,        0, 32'h0);   // r24
        add(0, 1, 32'h400,      1,  1,  0, 0, 32'h0,        32'h300,      0, 32'h0);   // r25
        add(0, 0, 32'h0,        1,  1,  0, 0, 32'h0,        32'h400,      0, 32'h0);   // r26
        add(0, 0, 32'h0,        0,  1,  1, 0, 32'h400,      32'h404,      0, 32'h0);   // r27
        // Reset mid-stream with a full queue.
        add(1, 0, 32'h0,        0,  1,  1, 0, 32'h400,      32'h408,      0, 32'h0);   // r28
`endif
        add(0, 0, 32'h0,        1,  1,  0, 1, 32'h0,        32'h0,        0, 32'h0);   // r29
        add(0, 0, 32'h0,        1,  1,  1, 0, 32'h0,        32'h4,        0, 32'h0);   // r30

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].chk) begin
                check_outputs($sformatf("r%0d", i), vecs[i].ev, vecs[i].dz, vecs[i].epc,
                              vecs[i].eimem, vecs[i].ef, vecs[i].efpc);
            end
            rst            = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            dec_ready      = vecs[i].rdy;
        end

        // Hand sequence: redirect to 0x80, then stall and release.
        @(negedge clk);
        rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; dec_ready = 1'b0;
        @(negedge clk);
        check_outputs("h1", 1'b0, 1'b0, 32'h0, 32'h80, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        @(negedge clk);
        check_outputs("h2", 1'b1, 1'b0, 32'h80, 32'h84, 1'b0, 32'h0);
        @(negedge clk);
        check_outputs("h3", 1'b1, 1'b0, 32'h80, 32'h88, 1'b0, 32'h0);
        @(negedge clk);
        check_outputs("h4", 1'b1, 1'b0, 32'h80, 32'h88, 1'b0, 32'h0);
        dec_ready = 1'b1;
        @(negedge clk);
        check_outputs("h5", 1'b1, 1'b0, 32'h84, 32'h8C, 1'b0, 32'h0);
        @(negedge clk);
        check_outputs("h6", 1'b1, 1'b0, 32'h88, 32'h90, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
